// File: rtl/bubble_host_pkg.sv
// Shared types and default timing for the bubble cartridge host reader.
// Holds the FSM state enum, default timing constants and the CRC-16 helper.
package bubble_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_REP,
    ST_OFFSET,
    ST_CAPTURE,
    ST_TAIL,
    ST_GAP
  } state_t;

  localparam int unsigned DEF_REP_DELAY    = 500;
  localparam int unsigned DEF_REP_WIDTH    = 341;
  localparam int unsigned DEF_DATA_OFFSET  = 200;
  localparam int unsigned DEF_BIT_PERIOD   = 48;
  localparam int unsigned DEF_PAGE_BYTES   = 64;
  localparam int unsigned DEF_SHIFT_WINDOW = 336992;
  localparam int unsigned DEF_BOOT_BYTES   = 128;
  localparam int unsigned DEF_BOOT_WINDOW  = 2193873;
  localparam int unsigned DEF_INTER_GAP    = 37500;

  // Window/gap counter width; the boot window (2193873) fits in 22 bits.
  localparam int unsigned CNT_W = 22;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // CRC-16-CCITT update, one byte, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/bubble_byte_assembler.sv
// Packs odd/even bit pairs into bytes: period k fills byte[2k]=even, byte[2k+1]=odd.
// The fourth sample completes the byte and raises byte_valid for one cycle.
module bubble_byte_assembler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample,
  input  logic       clear,
  input  logic       odd,
  input  logic       even,
  output logic [7:0] byte_data,
  output logic       byte_valid
);

  logic [1:0] idx;
  logic [5:0] part;

  // Collect bit pairs; clear drops any partial byte so the next access starts aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 2'd0;
      part       <= 6'd0;
      byte_data  <= 8'd0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (clear) begin
        idx  <= 2'd0;
        part <= 6'd0;
      end else if (sample) begin
        idx <= idx + 2'd1;
        unique case (idx)
          2'd0: part[1:0] <= {odd, even};
          2'd1: part[3:2] <= {odd, even};
          2'd2: part[5:4] <= {odd, even};
          default: begin
            byte_data  <= {odd, even, part};
            byte_valid <= 1'b1;
            part       <= 6'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/bubble_host_reader.sv
// Host-side bubble cartridge reader: drives shift/replicator strobes, captures page
// or boot data, enforces the inter-access gap.
// Optional feature macro: BUBBLE_READER_CRC_EN adds crc16/crc_valid outputs.
module bubble_host_reader
  import bubble_host_pkg::*;
#(
  parameter int unsigned REP_DELAY    = DEF_REP_DELAY,
  parameter int unsigned REP_WIDTH    = DEF_REP_WIDTH,
  parameter int unsigned DATA_OFFSET  = DEF_DATA_OFFSET,
  parameter int unsigned BIT_PERIOD   = DEF_BIT_PERIOD,
  parameter int unsigned PAGE_BYTES   = DEF_PAGE_BYTES,
  parameter int unsigned SHIFT_WINDOW = DEF_SHIFT_WINDOW,
  parameter int unsigned BOOT_BYTES   = DEF_BOOT_BYTES,
  parameter int unsigned BOOT_WINDOW  = DEF_BOOT_WINDOW,
  parameter int unsigned INTER_GAP    = DEF_INTER_GAP
) (
  input  logic        master_clock,
  input  logic        power_good,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_boot,
  input  logic        cmd_abort,
  output logic        bubble_shift_enable,
  output logic        replicator_enable,
  output logic        bootloop_enable,
  input  logic        bubble_out_odd,
  input  logic        bubble_out_even,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        done,
  output logic        aborted
`ifdef BUBBLE_READER_CRC_EN
  ,
  output logic [15:0] crc16,
  output logic        crc_valid
`endif
);

  localparam int unsigned REP_END   = REP_DELAY + REP_WIDTH;
  localparam int unsigned PAGE_CS   = REP_END + DATA_OFFSET;
  localparam int unsigned PAGE_BITS = PAGE_BYTES * 4;
  localparam int unsigned BOOT_BITS = BOOT_BYTES * 4;
  localparam int unsigned MAX_BITS  = (PAGE_BITS > BOOT_BITS) ? PAGE_BITS : BOOT_BITS;
  localparam int unsigned BITS_W    = $clog2(MAX_BITS + 1);
  localparam int unsigned PH_W      = $clog2(BIT_PERIOD + 1);

  // Capture must finish strictly inside the shift window.
  if (PAGE_CS + PAGE_BITS * BIT_PERIOD >= SHIFT_WINDOW) begin : g_page_chk
    $error("bubble_host_reader: page capture end exceeds SHIFT_WINDOW");
  end
  if (DATA_OFFSET + BOOT_BITS * BIT_PERIOD >= BOOT_WINDOW) begin : g_boot_chk
    $error("bubble_host_reader: boot capture end exceeds BOOT_WINDOW");
  end

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [PH_W-1:0]   phase;
  logic [BITS_W-1:0] bits;
  logic              boot_r;
  logic              abort_r;

  logic              in_access, abort_take, sample, accept, gap_end;
  logic [CNT_W-1:0]  cs_last, win_last;
  logic [BITS_W-1:0] bit_last;

  assign in_access  = (state == ST_LEAD) || (state == ST_REP) || (state == ST_OFFSET) ||
                      (state == ST_CAPTURE) || (state == ST_TAIL);
  assign abort_take = in_access && cmd_abort;
  assign accept     = (state == ST_IDLE) && cmd_valid && cmd_ready;
  assign sample     = (state == ST_CAPTURE) && (phase == PH_W'(BIT_PERIOD / 2));
  assign gap_end    = (state == ST_GAP) && (cnt == CNT_W'(INTER_GAP - 1));
  assign cs_last    = boot_r ? CNT_W'(DATA_OFFSET - 1) : CNT_W'(PAGE_CS - 1);
  assign win_last   = boot_r ? CNT_W'(BOOT_WINDOW - 1) : CNT_W'(SHIFT_WINDOW - 1);
  assign bit_last   = boot_r ? BITS_W'(BOOT_BITS - 1) : BITS_W'(PAGE_BITS - 1);

  // Access sequencer: one window counter times every strobe edge; abort wins over all.
  always_ff @(posedge master_clock or negedge power_good) begin
    if (!power_good) begin
      state               <= ST_IDLE;
      cnt                 <= '0;
      phase               <= '0;
      bits                <= '0;
      boot_r              <= 1'b0;
      abort_r             <= 1'b0;
      cmd_ready           <= 1'b0;
      bubble_shift_enable <= 1'b1;
      replicator_enable   <= 1'b1;
      bootloop_enable     <= 1'b0;
      done                <= 1'b0;
      aborted             <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (done && boot_r && !aborted) bootloop_enable <= 1'b1;
      if (abort_take) begin
        bubble_shift_enable <= 1'b1;
        replicator_enable   <= 1'b1;
        abort_r             <= 1'b1;
        cnt                 <= '0;
        state               <= ST_GAP;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (accept) begin
              cmd_ready           <= 1'b0;
              bubble_shift_enable <= 1'b0;
              cnt                 <= '0;
              boot_r              <= cmd_boot;
              abort_r             <= 1'b0;
              state               <= cmd_boot ? ST_OFFSET : ST_LEAD;
            end else begin
              cmd_ready <= 1'b1;
            end
          end
          ST_LEAD: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(REP_DELAY - 1)) begin
              replicator_enable <= 1'b0;
              state             <= ST_REP;
            end
          end
          ST_REP: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(REP_END - 1)) begin
              replicator_enable <= 1'b1;
              state             <= ST_OFFSET;
            end
          end
          ST_OFFSET: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == cs_last) begin
              phase <= '0;
              bits  <= '0;
              state <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            cnt <= cnt + CNT_W'(1);
            if (phase == PH_W'(BIT_PERIOD - 1)) begin
              phase <= '0;
              bits  <= bits + BITS_W'(1);
              if (bits == bit_last) state <= ST_TAIL;
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
          ST_TAIL: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == win_last) begin
              bubble_shift_enable <= 1'b1;
              cnt                 <= '0;
              state               <= ST_GAP;
            end
          end
          ST_GAP: begin
            cnt <= cnt + CNT_W'(1);
            if (gap_end) begin
              done      <= 1'b1;
              aborted   <= abort_r;
              cmd_ready <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  bubble_byte_assembler u_asm (
    .clk        (master_clock),
    .rst_n      (power_good),
    .sample     (sample),
    .clear      (abort_take),
    .odd        (bubble_out_odd),
    .even       (bubble_out_even),
    .byte_data  (byte_data),
    .byte_valid (byte_valid)
  );

`ifdef BUBBLE_READER_CRC_EN
  // Running CRC over captured bytes, restarted on accept; reported only for clean completions.
  always_ff @(posedge master_clock or negedge power_good) begin
    if (!power_good) begin
      crc16     <= CRC_INIT;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= gap_end && !abort_r;
      if (accept)          crc16 <= CRC_INIT;
      else if (byte_valid) crc16 <= crc16_byte(crc16, byte_data);
    end
  end
`endif

endmodule

// File: tb/tb_bubble_host_reader.sv
// Directed bench for bubble_host_reader with scaled-down timing parameters.
// Table of access vectors plus hand sequences for reset, gap and idle-abort corners.
module tb_bubble_host_reader;

  localparam int RD = 10, RW = 6, DO = 5, BP = 8, PB = 4, SW = 200, BB = 6, BW = 300, IG = 20;

  logic       clk = 1'b0;
  logic       power_good = 1'b1;
  logic       cmd_valid = 1'b0, cmd_boot = 1'b0, cmd_abort = 1'b0;
  logic       odd = 1'b0, even = 1'b0;
  logic       cmd_ready, shift, rep, bootloop, byte_valid, done, aborted;
  logic [7:0] byte_data;
`ifdef BUBBLE_READER_CRC_EN
  logic [15:0] crc16;
  logic        crc_valid;
`endif

  always #5 clk = ~clk;

  bubble_host_reader #(
    .REP_DELAY(RD), .REP_WIDTH(RW), .DATA_OFFSET(DO), .BIT_PERIOD(BP), .PAGE_BYTES(PB),
    .SHIFT_WINDOW(SW), .BOOT_BYTES(BB), .BOOT_WINDOW(BW), .INTER_GAP(IG)
  ) dut (
    .master_clock(clk), .power_good(power_good), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_boot(cmd_boot), .cmd_abort(cmd_abort), .bubble_shift_enable(shift),
    .replicator_enable(rep), .bootloop_enable(bootloop), .bubble_out_odd(odd),
    .bubble_out_even(even), .byte_data(byte_data), .byte_valid(byte_valid), .done(done),
    .aborted(aborted)
`ifdef BUBBLE_READER_CRC_EN
    , .crc16(crc16), .crc_valid(crc_valid)
`endif
  );

  typedef struct {
    logic       boot;
    logic       odd;
    logic       even;
    int         abort_at;   // window cycle during which cmd_abort is held, -1 = none
    int         shift_low;
    int         rep_first;
    int         rep_last;
    int         nbytes;
    logic [7:0] byte_val;
    int         first_bv;
    logic       ab;
    logic       bl_done;
    logic       bl_after;
  } vec_t;

  vec_t vt[8];
  int   nvec = 0, nmis = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Issue one command from a negedge where cmd_ready is high; returns at window cycle 0.
  task automatic issue(input logic boot);
    int g;
    g = 0;
    while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
    chk("ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_boot  = boot;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_boot  = 1'b0;
  endtask

  // Watch an access to its done strobe, tallying strobes and bytes, then check everything.
  task automatic run_vec(input vec_t v);
    int w, rf, rl, nb, badb, fbv, gap, rdy_busy, rep_idle, g;
    logic got, ab, bl_d, rdy_d;
    w = 0; rf = -1; rl = -1; nb = 0; badb = 0; fbv = -1; gap = 0; rdy_busy = 0; rep_idle = 0;
    got = 1'b0; ab = 1'b0; bl_d = 1'b0; rdy_d = 1'b0;
    odd = v.odd; even = v.even;
    issue(v.boot);
    for (g = 0; g < 2000; g++) begin
      if (done) begin
        got = 1'b1; ab = aborted; bl_d = bootloop; rdy_d = cmd_ready;
        break;
      end
      if (!shift) begin
        if (!rep) begin
          if (rf < 0) rf = w;
          rl = w;
        end
      end else begin
        gap++;
        if (!rep) rep_idle++;
      end
      cmd_abort = !shift && (w == v.abort_at);
      if (byte_valid) begin
        nb++;
        if (fbv < 0) fbv = w;
        if (byte_data !== v.byte_val) badb++;
      end
      if (cmd_ready) rdy_busy++;
      if (!shift) w++;
      @(negedge clk);
    end
    cmd_abort = 1'b0;
    chk("done_seen", int'(got), 1);
    chk("shift_low_cycles", w, v.shift_low);
    chk("rep_first", rf, v.rep_first);
    chk("rep_last", rl, v.rep_last);
    chk("rep_low_outside_window", rep_idle, 0);
    chk("byte_count", nb, v.nbytes);
    chk("bad_bytes", badb, 0);
    chk("first_byte_valid", fbv, v.first_bv);
    chk("gap_cycles", gap, IG);
    chk("aborted", int'(ab), int'(v.ab));
    chk("ready_at_done", int'(rdy_d), 1);
    chk("ready_while_busy", rdy_busy, 0);
    chk("bootloop_at_done", int'(bl_d), int'(v.bl_done));
    @(negedge clk);
    chk("bootloop_after_done", int'(bootloop), int'(v.bl_after));
    chk("done_one_cycle", int'(done), 0);
  endtask

  // Bounded wait for done; returns the observed aborted flag.
  task automatic wait_done(output logic got, output logic ab, output int low);
    got = 1'b0; ab = 1'b0; low = 0;
    for (int g = 0; g < 2000; g++) begin
      if (done) begin got = 1'b1; ab = aborted; break; end
      if (!shift) low++;
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_shift"}, int'(shift), 1);
    chk({tag, "_rep"}, int'(rep), 1);
    chk({tag, "_bootloop"}, int'(bootloop), 0);
    chk({tag, "_ready"}, int'(cmd_ready), 0);
    chk({tag, "_byte_valid"}, int'(byte_valid), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_aborted"}, int'(aborted), 0);
    chk({tag, "_byte_data"}, int'(byte_data), 0);
  endtask

`ifdef BUBBLE_READER_CRC_EN
  function automatic logic [15:0] crc_ref(input int n, input logic [7:0] b);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {b, 8'h00};
      for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction
`endif

  initial begin
    logic got, ab;
    int   low, cnt_bad;

    // page CS = 21, boot CS = 5; first byte_valid = CS + 3*BP + BP/2 + 1
    vt[0] = '{1'b0, 1'b1, 1'b0, -1, SW, 10, 15, PB, 8'hAA, 50, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, -1, SW, 10, 15, PB, 8'h55, 50, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 12, 13, 10, 12, 0, 8'hAA, -1, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b0, 70, 71, 10, 15, 1, 8'hAA, 50, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b1, -1, SW, 10, 15, PB, 8'h55, 50, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b1, 40, 41, -1, -1, 1, 8'hFF, 34, 1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b1, -1, BW, -1, -1, BB, 8'hFF, 34, 1'b0, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b0, -1, SW, 10, 15, PB, 8'hAA, 50, 1'b0, 1'b1, 1'b1};

    // Reset state and cmd_ready rising one cycle after release
    #2 power_good = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    power_good = 1'b1;
    #1 chk("ready_at_release", int'(cmd_ready), 0);
    @(negedge clk);
    chk("ready_after_release", int'(cmd_ready), 1);

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // cmd_valid during GAP is dropped, not queued
    issue(1'b0);
    @(negedge clk);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    chk("gap_abort_shift", int'(shift), 1);
    cnt_bad = 0;
    cmd_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!shift || cmd_ready) cnt_bad++;
    end
    cmd_valid = 1'b0;
    chk("gap_valid_ignored", cnt_bad, 0);
    wait_done(got, ab, low);
    chk("gap_done_seen", int'(got), 1);
    chk("gap_done_aborted", int'(ab), 1);
    @(negedge clk);
    chk("gap_no_queued_access", int'(shift), 1);

    // Abort in IDLE is ignored; valid+abort together in IDLE is an accept
    cnt_bad = 0;
    cmd_abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (!shift || !cmd_ready) cnt_bad++;
    end
    chk("idle_abort_ignored", cnt_bad, 0);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_abort = 1'b0;
    chk("valid_abort_accept", int'(shift), 0);
    wait_done(got, ab, low);
    chk("valid_abort_done", int'(got), 1);
    chk("valid_abort_not_aborted", int'(ab), 0);
    chk("valid_abort_shift_low", low, SW);
    @(negedge clk);

    // power_good low mid-CAPTURE: immediate reset, then a fresh access works
    odd = 1'b1; even = 1'b0;
    issue(1'b0);
    repeat (60) @(negedge clk);
    chk("midcap_byte_before", int'(byte_data), 8'hAA);
    #2 power_good = 1'b0;
    #1 chk_reset_outputs("midcap");
    @(negedge clk);
    power_good = 1'b1;
    @(negedge clk);
    chk("midcap_ready_after", int'(cmd_ready), 1);
    run_vec(vt[0]);

`ifdef BUBBLE_READER_CRC_EN
    // CRC over a page of zero bytes
    odd = 1'b0; even = 1'b0;
    issue(1'b0);
    wait_done(got, ab, low);
    chk("crc_done", int'(got), 1);
    chk("crc_valid", int'(crc_valid), 1);
    chk("crc16", int'(crc16), int'(crc_ref(PB, 8'h00)));
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
